// File: rtl/taxi_apb_if.sv
// APB4 bus bundle shared by taxi_apb_mst and APB peripherals.
// Address, control and write data flow mst -> slv; pready/prdata/pslverr flow back.
interface taxi_apb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned STRB_W = DATA_W / 8
);
    logic [ADDR_W-1:0] paddr;
    logic [2:0]        pprot;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport mst (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slv (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/taxi_apb_mst.sv
// APB4 initiator: one valid/ready command in, one APB transfer, one valid/ready response out.
// Optional ACCESS stall timeout is compiled in with TAXI_APB_MST_TIMEOUT_EN.
module taxi_apb_mst #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned STRB_W         = DATA_W / 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_strb,
    input  logic [2:0]        cmd_prot,
    input  logic              cmd_valid,
    output logic              cmd_ready,

    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              rsp_valid,
    input  logic              rsp_ready,

    taxi_apb_if.mst           m_apb
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]        state_q, state_nxt;

    logic [ADDR_W-1:0] paddr_q, paddr_nxt;
    logic [2:0]        pprot_q, pprot_nxt;
    logic              pwrite_q, pwrite_nxt;
    logic [DATA_W-1:0] pwdata_q, pwdata_nxt;
    logic [STRB_W-1:0] pstrb_q, pstrb_nxt;
    logic              psel_q, psel_nxt;
    logic              penable_q, penable_nxt;

    logic              cmd_ready_q, cmd_ready_nxt;
    logic [DATA_W-1:0] rdata_q, rdata_nxt;
    logic              err_q, err_nxt;
    logic              rsp_valid_q, rsp_valid_nxt;

`ifdef TAXI_APB_MST_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic              timeout_q, timeout_nxt;

    assign rsp_timeout = timeout_q;
`else
    // Parameter kept for a uniform interface; only the timeout build consumes it.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES >= 2);

    assign rsp_timeout = 1'b0;
`endif

    // Next-state and next-output logic; every register holds unless a state says otherwise.
    always_comb begin
        state_nxt  = state_q;
        paddr_nxt  = paddr_q;
        pprot_nxt  = pprot_q;
        pwrite_nxt = pwrite_q;
        pwdata_nxt = pwdata_q;
        pstrb_nxt  = pstrb_q;
        rdata_nxt  = rdata_q;
        err_nxt    = err_q;
`ifdef TAXI_APB_MST_TIMEOUT_EN
        cnt_nxt     = cnt_q;
        timeout_nxt = timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_ready_q && cmd_valid) begin
                    state_nxt  = SETUP;
                    paddr_nxt  = cmd_addr;
                    pprot_nxt  = cmd_prot;
                    pwrite_nxt = cmd_write;
                    pwdata_nxt = cmd_wdata;
                    pstrb_nxt  = cmd_write ? cmd_strb : '0;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
`ifdef TAXI_APB_MST_TIMEOUT_EN
                cnt_nxt   = '0;
`endif
            end
            ACCESS: begin
                // pready wins over the timeout limit in the same cycle.
                if (m_apb.pready) begin
                    state_nxt = RESP;
                    rdata_nxt = pwrite_q ? '0 : m_apb.prdata;
                    err_nxt   = m_apb.pslverr;
`ifdef TAXI_APB_MST_TIMEOUT_EN
                    timeout_nxt = 1'b0;
`endif
                end
`ifdef TAXI_APB_MST_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt   = RESP;
                    rdata_nxt   = '0;
                    err_nxt     = 1'b1;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        psel_nxt      = (state_nxt == SETUP) || (state_nxt == ACCESS);
        penable_nxt   = (state_nxt == ACCESS);
        cmd_ready_nxt = (state_nxt == IDLE);
        rsp_valid_nxt = (state_nxt == RESP);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pprot_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef TAXI_APB_MST_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_nxt;
            paddr_q     <= paddr_nxt;
            pprot_q     <= pprot_nxt;
            pwrite_q    <= pwrite_nxt;
            pwdata_q    <= pwdata_nxt;
            pstrb_q     <= pstrb_nxt;
            psel_q      <= psel_nxt;
            penable_q   <= penable_nxt;
            cmd_ready_q <= cmd_ready_nxt;
            rdata_q     <= rdata_nxt;
            err_q       <= err_nxt;
            rsp_valid_q <= rsp_valid_nxt;
`ifdef TAXI_APB_MST_TIMEOUT_EN
            cnt_q       <= cnt_nxt;
            timeout_q   <= timeout_nxt;
`endif
        end
    end

    assign m_apb.paddr   = paddr_q;
    assign m_apb.pprot   = pprot_q;
    assign m_apb.pwrite  = pwrite_q;
    assign m_apb.pwdata  = pwdata_q;
    assign m_apb.pstrb   = pstrb_q;
    assign m_apb.psel    = psel_q;
    assign m_apb.penable = penable_q;

    assign cmd_ready = cmd_ready_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_taxi_apb_mst.sv
// Directed + randomized bench for taxi_apb_mst with a memory-backed APB slave model.
// Timeout checks run only when TAXI_APB_MST_TIMEOUT_EN is defined for the build.
module tb_taxi_apb_mst;

    localparam int unsigned TO = 8;
`ifdef TAXI_APB_MST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] cmd_addr = '0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic [2:0]  cmd_prot = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_acc = 0;
    int last_len = 0;

    logic [31:0] mem [logic [31:0]];

    taxi_apb_if #(.DATA_W(32), .ADDR_W(32)) apb ();

    taxi_apb_mst #(
        .DATA_W(32), .ADDR_W(32), .STRB_W(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .cmd_strb(cmd_strb), .cmd_prot(cmd_prot), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .m_apb(apb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_0F0F;
    endfunction

    // One complete transfer: accept, SETUP, (waits+1) ACCESS cycles, response held rd extra cycles.
    task automatic xfer(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr, input int waits,
                        input bit err, input int rd, input bit b2b);
        bit ok;
        bit abort;
        int nacc;
        int acc;
        logic [31:0] exp_rdata;
        logic [31:0] cur;
        cmd_addr = a; cmd_write = wr; cmd_wdata = wd; cmd_strb = st; cmd_prot = pr;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
        end
        chk("accept_wait", 64'(ok), 64'd1);
        if (!ok) begin cmd_valid = 1'b0; return; end
        @(posedge clk); #1;
        acc = cyc;
        if (b2b) chk("issue_interval", 64'(acc - last_acc), 64'(last_len));
        cmd_valid = 1'b0;
        cmd_addr = $urandom; cmd_write = ~wr; cmd_wdata = $urandom; cmd_strb = 4'($urandom);

        abort = TO_EN && (waits > int'(TO) - 1);
        nacc = abort ? int'(TO) : waits + 1;
        exp_rdata = (wr || abort) ? 32'h0 : mem_rd(a);

        @(negedge clk);
        chk("setup_psel", 64'(apb.psel), 64'd1);
        chk("setup_penable", 64'(apb.penable), 64'd0);
        chk("setup_paddr", 64'(apb.paddr), 64'(a));
        chk("setup_pwrite", 64'(apb.pwrite), 64'(wr));
        chk("setup_pwdata", 64'(apb.pwdata), 64'(wd));
        chk("setup_pstrb", 64'(apb.pstrb), 64'(wr ? st : 4'h0));
        chk("setup_pprot", 64'(apb.pprot), 64'(pr));
        chk("setup_cmd_ready", 64'(cmd_ready), 64'd0);
        @(posedge clk); #1;

        for (int w = 0; w < nacc; w++) begin
            @(negedge clk);
            chk("access_psel", 64'(apb.psel), 64'd1);
            chk("access_penable", 64'(apb.penable), 64'd1);
            chk("access_paddr", 64'(apb.paddr), 64'(a));
            chk("access_pwdata", 64'(apb.pwdata), 64'(wd));
            chk("access_rsp_valid", 64'(rsp_valid), 64'd0);
            if (!abort && w == waits) begin
                apb.pready = 1'b1; apb.pslverr = err;
                apb.prdata = wr ? 32'($urandom) : mem_rd(a);
            end else begin
                apb.pready = 1'b0; apb.pslverr = 1'($urandom); apb.prdata = $urandom;
            end
            @(posedge clk); #1;
            apb.pready = 1'b0; apb.pslverr = 1'($urandom); apb.prdata = $urandom;
        end

        if (wr && !abort && !err) begin
            cur = mem_rd(a);
            for (int b = 0; b < 4; b++)
                if (st[b]) cur[8*b +: 8] = wd[8*b +: 8];
            mem[a] = cur;
        end

        for (int i = 0; i <= rd; i++) begin
            @(negedge clk);
            chk("rsp_valid", 64'(rsp_valid), 64'd1);
            chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
            chk("rsp_err", 64'(rsp_err), 64'(abort ? 1'b1 : err));
            chk("rsp_timeout", 64'(rsp_timeout), 64'(abort));
            chk("rsp_psel", 64'(apb.psel), 64'd0);
            chk("rsp_penable", 64'(apb.penable), 64'd0);
            chk("rsp_cmd_ready", 64'(cmd_ready), 64'd0);
            rsp_ready = (i == rd);
            if (i < rd) begin
                cmd_valid = 1'b1; cmd_addr = $urandom; cmd_wdata = $urandom;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        last_acc = acc;
        last_len = 3 + nacc + rd;
    endtask

    initial begin
        bit ok;
        apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
        mem[32'h100] = 32'hDEADBEEF;

        #2 rst_n = 1'b0;
        #5;
        chk("rst_psel", 64'(apb.psel), 64'd0);
        chk("rst_penable", 64'(apb.penable), 64'd0);
        chk("rst_pwrite", 64'(apb.pwrite), 64'd0);
        chk("rst_paddr", 64'(apb.paddr), 64'd0);
        chk("rst_pwdata", 64'(apb.pwdata), 64'd0);
        chk("rst_pstrb", 64'(apb.pstrb), 64'd0);
        chk("rst_pprot", 64'(apb.pprot), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
        @(posedge clk); #1;
        chk("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

        // Read, 0 wait states; strobes must be forced to 0.
        xfer(32'h100, 1'b0, 32'h0, 4'hF, 3'd2, 0, 1'b0, 0, 1'b0);
        // Write, 3 wait states.
        xfer(32'h20, 1'b1, 32'h12345678, 4'h5, 3'd1, 3, 1'b0, 0, 1'b1);
        xfer(32'h20, 1'b0, 32'h0, 4'h0, 3'd0, 1, 1'b0, 0, 1'b1);
        // Slave error with 5 cycles of response backpressure, next command pending.
        xfer(32'h44, 1'b0, 32'h0, 4'h0, 3'd0, 0, 1'b1, 5, 1'b1);
        xfer(32'h48, 1'b1, 32'hCAFEF00D, 4'hF, 3'd7, 0, 1'b0, 0, 1'b1);

        if (TO_EN) begin
            xfer(32'h300, 1'b0, 32'h0, 4'h0, 3'd0, 40, 1'b0, 0, 1'b1);
            xfer(32'h304, 1'b1, 32'h55AA55AA, 4'hF, 3'd0, 40, 1'b0, 0, 1'b1);
            xfer(32'h100, 1'b0, 32'h0, 4'h0, 3'd0, int'(TO) - 1, 1'b0, 0, 1'b1);
        end

        // Reset during an ACCESS wait state.
        cmd_addr = 32'h80; cmd_write = 1'b0; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
        end
        chk("mid_rst_accept", 64'(ok), 64'd1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_penable_before", 64'(apb.penable), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_psel", 64'(apb.psel), 64'd0);
        chk("mid_rst_penable", 64'(apb.penable), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        xfer(32'h100, 1'b0, 32'h0, 4'h0, 3'd3, 2, 1'b0, 0, 1'b0);

        // Back-to-back random stream against the memory model.
        for (int k = 0; k < 16; k++) begin
            xfer(32'h200 + 32'(4 * $urandom_range(0, 3)), 1'($urandom), $urandom,
                 4'($urandom), 3'($urandom), 0, 1'b0, 0, k != 0);
        end
        // Random waits, errors and backpressure.
        for (int k = 0; k < 8; k++) begin
            xfer(32'h200 + 32'(4 * $urandom_range(0, 3)), 1'($urandom), $urandom,
                 4'($urandom), 3'($urandom), int'($urandom_range(0, 4)),
                 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/taxi_apb_mst.md
# taxi_apb_mst

APB initiator that turns a simple valid/ready command stream into APB4 transfers and returns each completion on a valid/ready response stream. It drives the `mst` side of `taxi_apb_if`. It lets streaming or CSR-engine logic reach APB peripherals without building its own APB phase sequencing. The block handles one transfer at a time, with SETUP/ACCESS sequencing, wait states, error capture and an optional stall timeout.

## Interface

Parameters:
- `DATA_W`, 32, data width in bits; must match `m_apb`.
- `ADDR_W`, 32, address width in bits; must match `m_apb`.
- `STRB_W`, `DATA_W/8`, byte-strobe width.
- `TIMEOUT_CYCLES`, 1024, maximum ACCESS-phase cycles before abort; used only with `TAXI_APB_MST_TIMEOUT_EN`; must be ≥ 2.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_addr`  in  `ADDR_W`  transfer address.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_wdata`  in  `DATA_W`  write data.
- `cmd_strb`  in  `STRB_W`  write byte strobes.
- `cmd_prot`  in  3  protection attributes, passed to `pprot`.
- `cmd_valid`  in  1  command valid.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `rsp_rdata`  out  `DATA_W`  read data; 0 for writes.
- `rsp_err`  out  1  `pslverr`, or timeout abort.
- `rsp_timeout`  out  1  the transfer aborted on timeout; constant 0 when the feature is compiled out.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed.
- `m_apb`  `taxi_apb_if.mst`  APB bus: `paddr`, `pprot`, `psel`, `penable`, `pwrite`, `pwdata`, `pstrb`, `pready`, `prdata`, `pslverr`.

## Operation

- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, register addr, write, wdata, prot and strb into the APB output registers. On a read, `pstrb` is forced to 0.
  - Next state: SETUP.
- SETUP: `psel`=1, `penable`=0. Unconditionally go to ACCESS.
- ACCESS:
  - `psel`=1, `penable`=1. Address, control and data stay stable.
  - On `pready`=1: capture `prdata` (reads only; writes capture 0) and `pslverr` into the response registers. Drop `psel` and `penable`. Go to RESP.
  - On `pready`=0: stay in ACCESS (wait state).
- RESP:
  - `rsp_valid`=1. Response registers hold until `rsp_ready`=1, then go to IDLE.
  - `cmd_ready`=0 in every state except IDLE. A `cmd_valid` seen in RESP is accepted only after the return to IDLE.
- `psel` is deasserted between transfers; back-to-back transfers are not supported.
- `pready`, `prdata` and `pslverr` are ignored outside ACCESS.
- Command inputs are ignored outside the IDLE accept cycle.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronously). The FSM goes to IDLE and no response is produced.

## Timing

- Reset values:
  - `psel`, `penable`, `pwrite` = 0.
  - `paddr`, `pwdata`, `pstrb`, `pprot` = 0.
  - `cmd_ready`, `rsp_valid`, `rsp_err`, `rsp_timeout` = 0.
  - `rsp_rdata` = 0.
  - FSM = IDLE.
- `cmd_ready` returns high on the first clock edge after `rst_n` is released.
- All outputs are registered. There is no combinational path from `pready` or `rsp_ready` to any output.
- Command accepted at edge N (a 0-wait-state slave samples `pready`=1 at edge N+2):
  - `psel`=1 after edge N.
  - `penable`=1 after edge N+1.
  - `rsp_valid`=1 after edge N+2.
  - With `rsp_ready` held high, `cmd_ready`=1 after edge N+3.
- Minimum issue interval: 4 cycles per transfer.
- Each slave wait state adds 1 cycle.

## Configuration

Macro: `TAXI_APB_MST_TIMEOUT_EN`.

With the macro defined:
- A counter of `$clog2(TIMEOUT_CYCLES+1)` bits clears on entry to ACCESS and increments each ACCESS cycle with `pready`=0.
- When it reaches `TIMEOUT_CYCLES - 1` and `pready` is still 0:
  - Drop `psel` and `penable`.
  - Go to RESP with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
- Equal-cycle priority: `pready`=1 in the same cycle as the limit wins, and the transfer completes normally.

Without the macro:
- ACCESS waits on `pready` indefinitely.
- `rsp_timeout` is tied to 0.
- No counter is synthesized.

## Test plan

- **Read, 0 wait states:** `cmd_addr`=0x100, `cmd_write`=0; slave gives `prdata`=0xDEADBEEF, `pready`=1 on the first ACCESS cycle → `psel` high for 2 cycles, `pstrb`=0, `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, `rsp_valid` 3 cycles after accept.
- **Write, 3 wait states:** `cmd_addr`=0x20, `cmd_wdata`=0x12345678, `cmd_strb`=0x5 → `paddr`, `pwdata` and `pstrb`=0x5 stable across SETUP plus 4 ACCESS cycles; `rsp_rdata`=0; `rsp_valid` 6 cycles after accept.
- **Slave error plus response backpressure:** read with `pslverr`=1; `rsp_ready` held low for 5 cycles → `rsp_err`=1 and `rsp_valid` both held; `cmd_ready`=0 throughout; a pending `cmd_valid` is accepted one cycle after `rsp_ready`.
- **Timeout (macro on, `TIMEOUT_CYCLES`=8):** `pready` never asserted → ACCESS lasts 8 cycles, then `psel`=0, `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0. Separately, with `pready`=1 on the 8th ACCESS cycle → normal completion, `rsp_timeout`=0.
- **Reset mid-ACCESS:** `rst_n` pulled low during a wait state → `psel`, `penable` and `rsp_valid` fall to 0 without waiting for a clock; after release, a new command completes normally.
- **Back-to-back stream:** 16 random read/write commands with `cmd_valid` and `rsp_ready` held high → responses in order, each matching a bus-model scoreboard, one transfer every 4 cycles.
